// File: rtl/canvas_write_arbiter.sv
// ---------------------------------------------------------------------------
// canvas_write_arbiter
//
// This module is the only driver of the canvas frame-buffer write port
// (WIDTH x HEIGHT pixels, RGB565, linear address y*WIDTH + x). Two clients
// share the port:
//   - the brush engine, which turns one cursor stroke into 1 or 4 writes;
//   - the clear engine, which sweeps every address with a fill colour.
// The RAM throttles every write through mem_ready.
//
// Optional feature macro: CANVAS_WRITE_ARBITER_CLEAR_ABORT_EN
//   When defined, the clear_abort input is added. It stops a running sweep,
//   or cancels a queued clear, and clear_done pulses once in either case.
//
// Ports
//   CLOCK         in   system clock, rising edge
//   RESET_N       in   asynchronous active-low reset
//   brush_req     in   stroke request, held until brush_ack
//   brush_x/y     in   stroke origin (8 bits each)
//   brush_colour  in   stroke colour
//   brush_size    in   0 = single pixel, 1 = 2x2 block
//   brush_ack     out  one-cycle pulse when the stroke fields are captured
//   brush_done    out  one-cycle pulse when the stroke is complete
//   clear_req     in   clear request (pulse or level)
//   clear_colour  in   fill colour
//   clear_abort   in   (macro only) abort a pending or running clear
//   clear_busy    out  clear pending or running
//   clear_done    out  one-cycle pulse when the sweep ends
//   mem_ready     in   RAM accepts a write this cycle
//   wr_en         out  write valid
//   wr_addr       out  write address
//   wr_data       out  write data
//
// WIDTH*HEIGHT must fit in ADDR_W bits.
// ---------------------------------------------------------------------------
module canvas_write_arbiter #(
  parameter int WIDTH  = 96,
  parameter int HEIGHT = 64,
  parameter int ADDR_W = 13
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              brush_req,
  input  logic [7:0]        brush_x,
  input  logic [7:0]        brush_y,
  input  logic [15:0]       brush_colour,
  input  logic              brush_size,
  output logic              brush_ack,
  output logic              brush_done,
  input  logic              clear_req,
  input  logic [15:0]       clear_colour,
`ifdef CANVAS_WRITE_ARBITER_CLEAR_ABORT_EN
  input  logic              clear_abort,
`endif
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              mem_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BRUSH = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

  logic [1:0] state;
  logic       pending_clear;
  logic [7:0] brush_x_q;
  logic [7:0] brush_y_q;
  logic       brush_size_q;
  logic [1:0] slot_q;

  logic       abort_req;
  logic [1:0] next_slot;
  logic [8:0] next_x;
  logic [8:0] next_y;
  logic [8:0] first_x;
  logic [8:0] first_y;
  logic       slot_last;
  logic       slot_free;

`ifdef CANVAS_WRITE_ARBITER_CLEAR_ABORT_EN
  assign abort_req = clear_abort;
`else
  assign abort_req = 1'b0;
`endif

  // A pixel outside the canvas is skipped rather than written.
  function automatic logic pixel_clipped(input logic [8:0] px, input logic [8:0] py);
    return (32'(px) >= 32'(WIDTH)) || (32'(py) >= 32'(HEIGHT));
  endfunction

  // Linear address computed at full width, then truncated to the port width.
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [8:0] px, input logic [8:0] py);
    return ADDR_W'(32'(py) * 32'(WIDTH) + 32'(px));
  endfunction

  // Slot n of a 2x2 stroke covers (x + n[0], y + n[1]). Coordinates are
  // widened to 9 bits so x+1 / y+1 past 255 stay out of range instead of
  // wrapping to 0.
  always_comb begin
    next_slot = slot_q + 2'd1;
    next_x    = {1'b0, brush_x_q} + 9'(next_slot[0]);
    next_y    = {1'b0, brush_y_q} + 9'(next_slot[1]);
    first_x   = {1'b0, brush_x};
    first_y   = {1'b0, brush_y};
    slot_last = brush_size_q ? (slot_q == 2'd3) : 1'b1;
    // A slot finishes when its write is accepted, or at once if it is clipped.
    slot_free = !wr_en || mem_ready;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= S_IDLE;
      pending_clear <= 1'b0;
      brush_x_q     <= '0;
      brush_y_q     <= '0;
      brush_size_q  <= 1'b0;
      slot_q        <= '0;
      brush_ack     <= 1'b0;
      brush_done    <= 1'b0;
      clear_busy    <= 1'b0;
      clear_done    <= 1'b0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
    end else begin
      brush_ack  <= 1'b0;
      brush_done <= 1'b0;
      clear_done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (abort_req && pending_clear) begin
            pending_clear <= 1'b0;
            clear_busy    <= 1'b0;
            clear_done    <= 1'b1;
          end else if (pending_clear || clear_req) begin
            // Clear wins over a brush request seen in the same cycle.
            pending_clear <= 1'b0;
            clear_busy    <= 1'b1;
            state         <= S_CLEAR;
            wr_en         <= 1'b1;
            wr_addr       <= '0;
            wr_data       <= clear_colour;
          end else if (brush_req) begin
            brush_x_q    <= brush_x;
            brush_y_q    <= brush_y;
            brush_size_q <= brush_size;
            slot_q       <= 2'd0;
            brush_ack    <= 1'b1;
            state        <= S_BRUSH;
            wr_en        <= !pixel_clipped(first_x, first_y);
            wr_addr      <= pixel_addr(first_x, first_y);
            wr_data      <= brush_colour;
          end
        end

        S_BRUSH: begin
          // A stroke is never preempted; a clear request is queued instead.
          if (clear_req) begin
            pending_clear <= 1'b1;
            clear_busy    <= 1'b1;
          end
          if (slot_free) begin
            if (slot_last) begin
              wr_en      <= 1'b0;
              brush_done <= 1'b1;
              state      <= S_IDLE;
            end else begin
              slot_q  <= next_slot;
              wr_en   <= !pixel_clipped(next_x, next_y);
              wr_addr <= pixel_addr(next_x, next_y);
            end
          end
        end

        S_CLEAR: begin
          // wr_addr doubles as the sweep counter; wr_data keeps the fill colour.
          if (abort_req) begin
            wr_en      <= 1'b0;
            clear_busy <= 1'b0;
            clear_done <= 1'b1;
            state      <= S_IDLE;
          end else if (mem_ready) begin
            if (wr_addr == LAST_ADDR) begin
              wr_en      <= 1'b0;
              clear_busy <= 1'b0;
              clear_done <= 1'b1;
              state      <= S_IDLE;
            end else begin
              wr_addr <= wr_addr + ADDR_W'(1);
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_canvas_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_canvas_write_arbiter
//
// Self-checking bench for canvas_write_arbiter. It combines a table of
// hand-computed brush strokes, hand-written clear/priority/reset sequences,
// and random strokes under a random mem_ready. The random strokes are checked
// against a pixel-list model of the stroke rules. A negedge monitor records
// every accepted write and every pulse, and checks that stalled writes hold
// their address and data.
// ---------------------------------------------------------------------------
module tb_canvas_write_arbiter;

  localparam int W  = 96;
  localparam int H  = 64;
  localparam int AW = 13;

  logic          CLOCK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          brush_req = 1'b0;
  logic [7:0]    brush_x = '0;
  logic [7:0]    brush_y = '0;
  logic [15:0]   brush_colour = '0;
  logic          brush_size = 1'b0;
  logic          brush_ack;
  logic          brush_done;
  logic          clear_req = 1'b0;
  logic [15:0]   clear_colour = '0;
  logic          clear_abort = 1'b0;
  logic          clear_busy;
  logic          clear_done;
  logic          mem_ready = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;

  canvas_write_arbiter #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .CLOCK        (CLOCK),
    .RESET_N      (RESET_N),
    .brush_req    (brush_req),
    .brush_x      (brush_x),
    .brush_y      (brush_y),
    .brush_colour (brush_colour),
    .brush_size   (brush_size),
    .brush_ack    (brush_ack),
    .brush_done   (brush_done),
    .clear_req    (clear_req),
    .clear_colour (clear_colour),
`ifdef CANVAS_WRITE_ARBITER_CLEAR_ABORT_EN
    .clear_abort  (clear_abort),
`endif
    .clear_busy   (clear_busy),
    .clear_done   (clear_done),
    .mem_ready    (mem_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic        sz;
    logic [15:0] col;
    int          nw;
    int          a0;
    int          a1;
    int          a2;
    int          a3;
    int          lat;
  } vec_t;

  int  n_checks = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  mem_mode = 0;
  wr_t got_q[$];
  wr_t exp_q[$];
  int  ack_cnt = 0, done_cnt = 0, cdone_cnt = 0;
  int  ack_cyc = 0, done_cyc = 0, cdone_cyc = 0;
  logic          prev_stall;
  logic [AW-1:0] prev_addr;
  logic [15:0]   prev_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #2;
  endtask

  // mem_ready pattern: 0 always ready, 1 toggling, 2 random.
  initial begin
    forever begin
      @(posedge CLOCK);
      #1;
      case (mem_mode)
        0:       mem_ready = 1'b1;
        1:       mem_ready = ~mem_ready;
        2:       mem_ready = 1'($urandom_range(0, 1));
        default: mem_ready = 1'b0;
      endcase
    end
  end

  // The monitor records accepted writes and pulses, and checks stall stability.
  initial begin
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge CLOCK);
      cyc++;
      if (!RESET_N) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          check("stall_hold", {wr_en, wr_addr, wr_data}, {1'b1, prev_addr, prev_data});
        if (wr_en && mem_ready) got_q.push_back('{cyc, wr_addr, wr_data});
        if (brush_ack) begin ack_cnt++; ack_cyc = cyc; end
        if (brush_done) begin done_cnt++; done_cyc = cyc; end
        if (clear_done) begin
          cdone_cnt++;
          cdone_cyc = cyc;
          check("busy_low_at_done", clear_busy, 0);
        end
        prev_stall = wr_en && !mem_ready;
        prev_addr  = wr_addr;
        prev_data  = wr_data;
      end
    end
  end

  // Reference model: list of the pixels a stroke must write, in order.
  function automatic void model_stroke(input int x, input int y, input bit sz, input logic [15:0] col);
    int px, py;
    exp_q.delete();
    for (int dy = 0; dy <= int'(sz); dy++) begin
      for (int dx = 0; dx <= int'(sz); dx++) begin
        px = x + dx;
        py = y + dy;
        if (px < W && py < H) exp_q.push_back('{0, AW'(py * W + px), col});
      end
    end
  endfunction

  // Runs one stroke. It can also raise clear_req in the request cycle, or for
  // one cycle during the stroke.
  task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic sz,
                               input logic [15:0] col, input bit with_clear, input bit mid_clear);
    int a0, d0, g;
    a0 = ack_cnt;
    d0 = done_cnt;
    got_q.delete();
    tick();
    brush_x = x; brush_y = y; brush_size = sz; brush_colour = col; brush_req = 1'b1;
    if (with_clear) clear_req = 1'b1;
    g = 0;
    while (ack_cnt == a0 && g < 20000) begin
      tick();
      clear_req = 1'b0;
      g++;
    end
    brush_req = 1'b0;
    check("ack_seen", ack_cnt - a0, 1);
    if (mid_clear) begin
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      check("busy_while_pending", clear_busy, 1);
    end
    g = 0;
    while (done_cnt == d0 && g < 200) begin tick(); g++; end
    check("done_seen", done_cnt - d0, 1);
    check("single_ack", ack_cnt - a0, 1);
  endtask

  // Compares the writes made between brush_ack and brush_done with exp_q.
  task automatic checkOutput(input string name);
    wr_t sel[$];
    foreach (got_q[i])
      if (got_q[i].cyc >= ack_cyc && got_q[i].cyc < done_cyc) sel.push_back(got_q[i]);
    check({name, "_count"}, sel.size(), exp_q.size());
    for (int i = 0; i < sel.size() && i < exp_q.size(); i++)
      check($sformatf("%s_wr%0d", name, i), {sel[i].addr, sel[i].data}, {exp_q[i].addr, exp_q[i].data});
  endtask

  task automatic wait_clear(input int c0, input int budget);
    int g;
    g = 0;
    while (cdone_cnt == c0 && g < budget) begin tick(); g++; end
    check("clear_done_seen", cdone_cnt - c0, 1);
  endtask

  // A full sweep must be addresses 0..W*H-1 in order, all with the fill colour.
  task automatic check_clear(input string name, input int start, input logic [15:0] col);
    int n, bad, first_bad;
    n = 0; bad = 0; first_bad = -1;
    foreach (got_q[i]) begin
      if (got_q[i].cyc >= start) begin
        if (got_q[i].addr !== AW'(n) || got_q[i].data !== col) begin
          bad++;
          if (first_bad < 0) first_bad = n;
        end
        n++;
      end
    end
    check({name, "_count"}, n, W * H);
    check($sformatf("%s_order(first bad idx %0d)", name, first_bad), bad, 0);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t tbl[10];
    int   c0, g, start;
    logic [7:0] rx, ry;
    logic       rs;
    logic [15:0] rc;

    tbl[0] = '{8'd10,  8'd5,   1'b0, 16'hF800, 1, 490,  0,    0,    0,    1};
    tbl[1] = '{8'd95,  8'd63,  1'b1, 16'h1234, 1, 6143, 0,    0,    0,    4};
    tbl[2] = '{8'd0,   8'd0,   1'b1, 16'h07E0, 4, 0,    1,    96,   97,   4};
    tbl[3] = '{8'd94,  8'd62,  1'b1, 16'hBEEF, 4, 6046, 6047, 6142, 6143, 4};
    tbl[4] = '{8'd96,  8'd0,   1'b0, 16'hFFFF, 0, 0,    0,    0,    0,    1};
    tbl[5] = '{8'd255, 8'd255, 1'b1, 16'hAAAA, 0, 0,    0,    0,    0,    4};
    tbl[6] = '{8'd95,  8'd10,  1'b1, 16'h5555, 2, 1055, 1151, 0,    0,    4};
    tbl[7] = '{8'd3,   8'd63,  1'b1, 16'h0F0F, 2, 6051, 6052, 0,    0,    4};
    tbl[8] = '{8'd0,   8'd64,  1'b0, 16'h00FF, 0, 0,    0,    0,    0,    1};
    tbl[9] = '{8'd95,  8'd0,   1'b0, 16'h8001, 1, 95,   0,    0,    0,    1};

    // Reset: outputs are zero both while reset is held and after release.
    mem_mode = 0;
    #1;
    check("reset_outputs_held", {brush_ack, brush_done, clear_busy, clear_done, wr_en, wr_addr, wr_data}, 0);
    repeat (3) tick();
    RESET_N = 1'b1;
    repeat (2) tick();
    check("reset_outputs_after", {brush_ack, brush_done, clear_busy, clear_done, wr_en, wr_addr, wr_data}, 0);

    // Table-driven strokes with mem_ready always high.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].x, tbl[i].y, tbl[i].sz, tbl[i].col, 1'b0, 1'b0);
      check($sformatf("tbl%0d_latency", i), done_cyc - ack_cyc, tbl[i].lat);
      exp_q.delete();
      if (tbl[i].nw > 0) exp_q.push_back('{0, AW'(tbl[i].a0), tbl[i].col});
      if (tbl[i].nw > 1) exp_q.push_back('{0, AW'(tbl[i].a1), tbl[i].col});
      if (tbl[i].nw > 2) exp_q.push_back('{0, AW'(tbl[i].a2), tbl[i].col});
      if (tbl[i].nw > 3) exp_q.push_back('{0, AW'(tbl[i].a3), tbl[i].col});
      checkOutput($sformatf("tbl%0d", i));
    end

    // Full clear with mem_ready toggling every cycle.
    $display("[TB] clear sweep with toggling mem_ready");
    mem_mode = 1;
    got_q.delete();
    c0 = cdone_cnt;
    tick();
    start = cyc;
    clear_colour = 16'h001F;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (4) tick();
    check("clear_busy_running", clear_busy, 1);
    wait_clear(c0, 20000);
    check_clear("clear_toggle", start, 16'h001F);
    repeat (5) tick();
    check("clear_done_once", cdone_cnt - c0, 1);
    check("clear_busy_after", clear_busy, 0);

    // Brush request raised mid-clear is served only after clear_done.
    $display("[TB] brush request during clear");
    mem_mode = 0;
    c0 = cdone_cnt;
    clear_colour = 16'h3333;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (50) tick();
    applyStimulus(8'd20, 8'd30, 1'b1, 16'hC0DE, 1'b0, 1'b0);
    check("midclear_clear_done", cdone_cnt - c0, 1);
    check("midclear_ack_after_done", ack_cyc - cdone_cyc, 1);
    model_stroke(20, 30, 1'b1, 16'hC0DE);
    checkOutput("midclear_stroke");

    // Clear and brush requested in the same idle cycle: clear goes first.
    $display("[TB] simultaneous clear and brush request");
    c0 = cdone_cnt;
    clear_colour = 16'h7777;
    applyStimulus(8'd1, 8'd2, 1'b0, 16'h4242, 1'b1, 1'b0);
    check("same_cycle_clear_done", cdone_cnt - c0, 1);
    check("same_cycle_ack_after_done", ack_cyc - cdone_cyc, 1);
    model_stroke(1, 2, 1'b0, 16'h4242);
    checkOutput("same_cycle_stroke");

    // A clear pulse during a 2x2 stroke starts right after brush_done.
    $display("[TB] clear request during a 2x2 stroke");
    c0 = cdone_cnt;
    clear_colour = 16'h0A0A;
    applyStimulus(8'd50, 8'd40, 1'b1, 16'hFACE, 1'b0, 1'b1);
    check("queued_latency", done_cyc - ack_cyc, 4);
    model_stroke(50, 40, 1'b1, 16'hFACE);
    checkOutput("queued_stroke");
    wait_clear(c0, 20000);
    check_clear("queued_clear", done_cyc + 1, 16'h0A0A);
    g = -1;
    foreach (got_q[i]) if (g < 0 && got_q[i].cyc > done_cyc) g = got_q[i].cyc;
    check("queued_clear_start", g - done_cyc, 1);

    // Reset during a clear at address 3000: asynchronous zeroing, no clear_done.
    $display("[TB] reset in the middle of a clear");
    c0 = cdone_cnt;
    clear_colour = 16'h9999;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    g = 0;
    while (wr_addr != AW'(3000) && g < 10000) begin tick(); g++; end
    check("reset_reached_3000", wr_addr, 3000);
    RESET_N = 1'b0;
    #1;
    check("reset_async_zero", {brush_ack, brush_done, clear_busy, clear_done, wr_en, wr_addr, wr_data}, 0);
    repeat (3) tick();
    RESET_N = 1'b1;
    repeat (4) tick();
    check("reset_no_clear_done", cdone_cnt - c0, 0);
    check("reset_idle_outputs", {clear_busy, wr_en}, 0);
    applyStimulus(8'd7, 8'd7, 1'b0, 16'h0101, 1'b0, 1'b0);
    model_stroke(7, 7, 1'b0, 16'h0101);
    checkOutput("post_reset_stroke");

`ifdef CANVAS_WRITE_ARBITER_CLEAR_ABORT_EN
    // Abort at address 100: writes stop after 100, one clear_done.
    $display("[TB] clear abort at address 100");
    mem_mode = 0;
    got_q.delete();
    c0 = cdone_cnt;
    clear_colour = 16'h2222;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    g = 0;
    while (wr_addr != AW'(100) && g < 1000) begin tick(); g++; end
    clear_abort = 1'b1;
    tick();
    clear_abort = 1'b0;
    repeat (4) tick();
    check("abort_clear_done", cdone_cnt - c0, 1);
    check("abort_wr_en", wr_en, 0);
    check("abort_busy", clear_busy, 0);
    check("abort_count", got_q.size(), 101);
    if (got_q.size() > 0) check("abort_last_addr", got_q[got_q.size() - 1].addr, 100);
`endif

    // Random strokes under a random mem_ready, checked against the model.
    $display("[TB] random strokes");
    mem_mode = 2;
    for (int i = 0; i < 40; i++) begin
      rx = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(88, 99));
      ry = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(56, 67));
      rs = 1'($urandom_range(0, 1));
      rc = 16'($urandom);
      applyStimulus(rx, ry, rs, rc, 1'b0, 1'b0);
      model_stroke(int'(rx), int'(ry), rs, rc);
      checkOutput($sformatf("rand%0d", i));
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
